// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the MOV/MOC memory responder
package mem_pkg;

  localparam logic [1:0] TD_BYTE = 2'b00;
  localparam logic [1:0] TD_HALF = 2'b01;
  localparam logic [1:0] TD_WORD = 2'b10;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Lane 0 (mask bit 3) is the byte at the request address, i.e. the MSB.
  function automatic logic [3:0] lane_mask(input logic [1:0] td);
    case (td)
      TD_BYTE: return 4'b1000;
      TD_HALF: return 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - byte store with four wrapping byte-lane ports
module mem_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [7:0]        mem       [2**ADDR_W];
  logic [ADDR_W-1:0] lane_addr [4];

  // Lane i sits at addr+i and occupies rdata/wdata bits [31-8i -: 8].
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign lane_addr[i]        = addr + ADDR_W'(i);
    assign rdata[31-8*i -: 8]  = mem[lane_addr[i]];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[3-i]) mem[lane_addr[i]] <= wdata[31-8*i -: 8];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - MOV/MOC memory responder; MEM_ALIGN_CHECK_EN enables misaligned-access trapping
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              MOV,
  input  logic              RW,
  input  logic [1:0]        typeData,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MOC,
  output logic              ERR
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [1:0]        td_q;
  logic [31:0]       din_q;
  logic [31:0]       rdata;
  logic [31:0]       rd_aligned;
  logic [31:0]       wdata;
  logic [3:0]        we;
  logic              misalign;
  logic              complete;

  mem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (CLK),
    .addr  (addr_q),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata)
  );

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = ((td_q == TD_HALF) && addr_q[0]) ||
                    ((td_q != TD_BYTE) && (td_q != TD_HALF) && (addr_q[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // The access fires on the WAIT edge that sees an expired counter, so
  // completion lands WAIT_CYCLES+1 edges after acceptance.
  assign complete = (state == WAIT) && MOV && (cnt == '0);

  always_comb begin
    we         = '0;
    wdata      = din_q;
    rd_aligned = rdata;
    case (td_q)
      TD_BYTE: begin
        wdata      = {din_q[7:0], 24'b0};
        rd_aligned = {24'b0, rdata[31:24]};
      end
      TD_HALF: begin
        wdata      = {din_q[15:0], 16'b0};
        rd_aligned = {16'b0, rdata[31:16]};
      end
      default: ;
    endcase
    if (complete && !rw_q && !misalign) we = lane_mask(td_q);
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state   <= IDLE;
      cnt     <= '0;
      MOC     <= 1'b0;
      ERR     <= 1'b0;
      DataOut <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      td_q    <= TD_BYTE;
      din_q   <= '0;
    end else begin
      case (state)
        IDLE: if (MOV) begin
          addr_q <= address;
          rw_q   <= RW;
          td_q   <= typeData;
          din_q  <= DataIn;
          cnt    <= CNT_W'(WAIT_CYCLES);
          state  <= WAIT;
        end
        WAIT: begin
          if (!MOV) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state <= DONE;
            MOC   <= 1'b1;
            ERR   <= misalign;
            if (rw_q && !misalign) DataOut <= rd_aligned;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: if (!MOV) begin
          state <= IDLE;
          MOC   <= 1'b0;
          ERR   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;
  import mem_pkg::*;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        MOV = 1'b0;
  logic        RW  = 1'b0;
  logic [1:0]  typeData = 2'b00;
  logic [7:0]  address  = 8'h00;
  logic [31:0] DataIn   = 32'h0;
  logic [31:0] DataOut;
  logic        MOC;
  logic        ERR;

  int tests = 0;
  int fails = 0;

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .MOV      (MOV),
    .RW       (RW),
    .typeData (typeData),
    .address  (address),
    .DataIn   (DataIn),
    .DataOut  (DataOut),
    .MOC      (MOC),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One MOV/MOC handshake; request lines are scrambled right after acceptance.
  task automatic do_op(input string tag, input logic rw, input logic [1:0] td,
                       input logic [7:0] a, input logic [31:0] d, input int hold,
                       output logic [31:0] q, output logic e, output int lat);
    int n;
    @(negedge CLK);
    MOV = 1'b1; RW = rw; typeData = td; address = a; DataIn = d;
    @(posedge CLK); #1;
    RW = ~rw; typeData = ~td; address = ~a; DataIn = ~d;
    n = 0;
    while (MOC !== 1'b1 && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    lat = n;
    check({tag, "_moc_rise"}, {31'b0, MOC}, 32'h1);
    q = DataOut;
    e = ERR;
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      check({tag, "_hold_moc"}, {31'b0, MOC}, 32'h1);
      check({tag, "_hold_data"}, DataOut, q);
    end
    @(negedge CLK);
    MOV = 1'b0;
    @(posedge CLK); #1;
    check({tag, "_moc_fall"}, {31'b0, MOC}, 32'h0);
    check({tag, "_err_fall"}, {31'b0, ERR}, 32'h0);
  endtask

  task automatic rd(input string tag, input logic [1:0] td, input logic [7:0] a,
                    input logic [31:0] exp);
    logic [31:0] q; logic e; int lat;
    do_op(tag, 1'b1, td, a, 32'h0, 0, q, e, lat);
    check(tag, q, exp);
  endtask

  task automatic wr(input string tag, input logic [1:0] td, input logic [7:0] a,
                    input logic [31:0] d, input logic exp_err);
    logic [31:0] q; logic e; int lat;
    do_op(tag, 1'b0, td, a, d, 0, q, e, lat);
    check({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
  endtask

  logic [31:0] q;
  logic        e;
  int          lat;
  logic        wrap_err;

  initial begin
`ifdef MEM_ALIGN_CHECK_EN
    wrap_err = 1'b1;
`else
    wrap_err = 1'b0;
`endif
    repeat (2) @(posedge CLK);
    #1;
    check("rst_moc", {31'b0, MOC}, 32'h0);
    check("rst_data", DataOut, 32'h0);
    check("rst_err", {31'b0, ERR}, 32'h0);
    @(negedge CLK);
    CLR = 1'b1;

    do_op("wr_word", 1'b0, TD_WORD, 8'h10, 32'hDEADBEEF, 0, q, e, lat);
    check("wr_word_lat", lat, 32'd3);
    check("wr_word_keep_data", q, 32'h0);
    do_op("rd_word", 1'b1, TD_WORD, 8'h10, 32'h0, 0, q, e, lat);
    check("rd_word_lat", lat, 32'd3);
    check("rd_word", q, 32'hDEADBEEF);
    rd("rd_b10", TD_BYTE, 8'h10, 32'h000000DE);
    rd("rd_b11", TD_BYTE, 8'h11, 32'h000000AD);
    rd("rd_b12", TD_BYTE, 8'h12, 32'h000000BE);
    rd("rd_b13", TD_BYTE, 8'h13, 32'h000000EF);
    rd("rd_h12", TD_HALF, 8'h12, 32'h0000BEEF);

    do_op("wr_b13", 1'b0, TD_BYTE, 8'h13, 32'hFFFFFF55, 0, q, e, lat);
    check("wr_b13_keep_data", q, 32'h0000BEEF);
    rd("rd_word_after_b", TD_WORD, 8'h10, 32'hDEADBE55);

    wr("wr_pre_fe", TD_BYTE, 8'hFE, 32'h000000AA, 1'b0);
    wr("wr_wrap", TD_WORD, 8'hFE, 32'h01020304, wrap_err);
`ifdef MEM_ALIGN_CHECK_EN
    rd("rd_fe_suppr", TD_BYTE, 8'hFE, 32'h000000AA);
`else
    rd("rd_fe", TD_BYTE, 8'hFE, 32'h00000001);
    rd("rd_ff", TD_BYTE, 8'hFF, 32'h00000002);
    rd("rd_00", TD_BYTE, 8'h00, 32'h00000003);
    rd("rd_01", TD_BYTE, 8'h01, 32'h00000004);
    rd("rd_wrap_word", TD_WORD, 8'hFE, 32'h01020304);
    rd("rd_wrap_half", TD_HALF, 8'hFF, 32'h00000203);
`endif

    wr("wr_pre_20", TD_WORD, 8'h20, 32'hCAFEF00D, 1'b0);
    @(negedge CLK);
    MOV = 1'b1; RW = 1'b0; typeData = TD_WORD; address = 8'h20; DataIn = 32'h12345678;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(negedge CLK);
    MOV = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      check("abort_moc", {31'b0, MOC}, 32'h0);
    end
    rd("rd_after_abort", TD_WORD, 8'h20, 32'hCAFEF00D);

    do_op("hold", 1'b1, TD_WORD, 8'h10, 32'h0, 5, q, e, lat);
    check("hold_data", q, 32'hDEADBE55);
    do_op("back2back", 1'b1, TD_HALF, 8'h10, 32'h0, 0, q, e, lat);
    check("back2back_lat", lat, 32'd3);
    check("back2back_data", q, 32'h0000DEAD);
    rd("rd_pre_rst", TD_WORD, 8'h10, 32'hDEADBE55);

    @(negedge CLK);
    MOV = 1'b1; RW = 1'b0; typeData = TD_WORD; address = 8'h10; DataIn = 32'h11111111;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(negedge CLK);
    CLR = 1'b0;
    #1;
    check("rst_mid_moc", {31'b0, MOC}, 32'h0);
    check("rst_mid_data", DataOut, 32'h0);
    MOV = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    CLR = 1'b1;
    rd("rd_after_rst", TD_WORD, 8'h10, 32'hDEADBE55);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
